// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter for a single-port data memory with
// registered read data. The pipeline memory stage has priority over the
// loader/debug port. Read data is returned one cycle after the grant, to
// whichever requester owned that read.
// Optional feature: define STARVE_GUARD_EN to enable the loader starvation
// guard. After STARVE_LIMIT consecutive loader denials, the loader gets one
// forced grant. When the macro is undefined, the pipeline has strict priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned DATA_W       = 24,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // pipeline memory-stage port
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_stall,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_rvalid,
  // loader / debug port
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_rvalid,
  // shared memory port
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q
);

  // Reject a starvation limit too wide to be a sensible denial count.
  if (STARVE_LIMIT > 32'd65535) begin : g_limit_check
    $error("mem_arbiter: STARVE_LIMIT out of range");
  end

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_PIPE = 2'd1,
    OWN_LOAD = 2'd2
  } owner_e;

  owner_e owner_q;
  owner_e owner_d;

  logic pipe_win;
  logic load_win;
  logic force_load;

`ifdef STARVE_GUARD_EN
  localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;

  // The loader wins a conflict once it has been denied STARVE_LIMIT times in a row.
  always_comb begin
    force_load = (starve_cnt_q == CNT_W'(STARVE_LIMIT)) && p_req && l_req;
  end

  // Count consecutive loader denials. Clear on a grant or when the loader goes idle.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!l_req || load_win) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // Denial counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  // Strict pipeline priority: the loader is never forced through.
  always_comb begin
    force_load = 1'b0;
  end
`endif

  // Same-cycle grant decision. All requests are ignored while reset is asserted.
  always_comb begin
    pipe_win = 1'b0;
    load_win = 1'b0;
    if (!rst) begin
      if (p_req && !force_load) begin
        pipe_win = 1'b1;
      end else if (l_req) begin
        load_win = 1'b1;
      end
    end
  end

  // Steer the winner onto the memory port. The port is zeroed when nobody wins.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (pipe_win) begin
      mem_addr  = p_addr;
      mem_wdata = p_wdata;
      mem_we    = p_we;
    end else if (load_win) begin
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
      mem_we    = l_we;
    end
  end

  // Grant handshakes. The pipeline stalls only when the loader takes the port from it.
  always_comb begin
    l_gnt   = load_win;
    p_stall = p_req && load_win;
  end

  // Return-owner state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_IDLE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // The next owner is the winner of a granted read. Writes return nothing.
  always_comb begin
    owner_d = OWN_IDLE;
    if (pipe_win && !p_we) begin
      owner_d = OWN_PIPE;
    end else if (load_win && !l_we) begin
      owner_d = OWN_LOAD;
    end
  end

  // Route registered memory data to the owner. Reset suppresses a read that is still in flight.
  always_comb begin
    p_rvalid = 1'b0;
    p_rdata  = '0;
    l_rvalid = 1'b0;
    l_rdata  = '0;
    if (!rst) begin
      unique case (owner_q)
        OWN_PIPE: begin
          p_rvalid = 1'b1;
          p_rdata  = mem_q;
        end
        OWN_LOAD: begin
          l_rvalid = 1'b1;
          l_rdata  = mem_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter. The stimulus task checks same-cycle grant and
// mux outputs, and queues the expected read responses. A separate monitor pops
// and compares those responses whenever the DUT raises an rvalid.
// The starvation expectations follow STARVE_GUARD_EN.
module tb_mem_arbiter;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 24;
  localparam int unsigned SL = 4;

  logic          clk;
  logic          rst;
  logic          p_req, p_we, l_req, l_we;
  logic [AW-1:0] p_addr, l_addr, mem_addr;
  logic [DW-1:0] p_wdata, l_wdata, mem_wdata, mem_q;
  logic [DW-1:0] p_rdata, l_rdata;
  logic          p_stall, p_rvalid, l_gnt, l_rvalid, mem_we;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rdata(l_rdata), .l_rvalid(l_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory with a registered read (read-before-write on the same edge).
  logic [DW-1:0] mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem_q = '0;
  end
  always @(posedge clk) begin
    mem_q <= mem[mem_addr[9:0]];
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_load;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;
  rsp_t sb[$];

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Drive one cycle. win: 0 = nobody, 1 = pipeline, 2 = loader. exp_rd is the expected read data.
  task automatic step(input bit r, input bit pr, input bit pwe, input logic [AW-1:0] pa,
                      input logic [DW-1:0] pd, input bit lr, input bit lwe,
                      input logic [AW-1:0] la, input logic [DW-1:0] ld,
                      input int win, input logic [DW-1:0] exp_rd);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit            ew;
    @(negedge clk);
    rst = r; p_req = pr; p_we = pwe; p_addr = pa; p_wdata = pd;
    l_req = lr; l_we = lwe; l_addr = la; l_wdata = ld;
    if (r) sb.delete();
    #1;
    ea = '0; ed = '0; ew = 1'b0;
    if (win == 1) begin ea = pa; ed = pd; ew = pwe; end
    if (win == 2) begin ea = la; ed = ld; ew = lwe; end
    chk("l_gnt", l_gnt, (win == 2));
    chk("p_stall", p_stall, (pr && win == 2));
    chk("mem_we", mem_we, ew);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    if (r) begin
      chk("rst_p_rvalid", p_rvalid, 0);
      chk("rst_l_rvalid", l_rvalid, 0);
      chk("rst_p_rdata", p_rdata, 0);
      chk("rst_l_rdata", l_rdata, 0);
    end
    if (win == 1 && !pwe) sb.push_back('{1'b0, exp_rd, cyc + 1});
    if (win == 2 && !lwe) sb.push_back('{1'b1, exp_rd, cyc + 1});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, '0, '0, 0, '0);
  endtask

  // Response monitor: checks owner, data, latency and the zeroed non-owner outputs.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (p_rvalid || l_rvalid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got p_rvalid=%0b l_rvalid=%0b expected none (cycle %0d)",
                   p_rvalid, l_rvalid, cyc);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp_l_rvalid", l_rvalid, e.is_load);
          chk("rsp_p_rvalid", p_rvalid, !e.is_load);
          chk("rsp_data", e.is_load ? l_rdata : p_rdata, e.data);
          chk("rsp_other_rdata", e.is_load ? p_rdata : l_rdata, 0);
          chk("rsp_latency", cyc, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL rsp_missing: got no rvalid expected %s data %0h (cycle %0d)",
                 sb[0].is_load ? "loader" : "pipeline", sb[0].data, cyc);
        void'(sb.pop_front());
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1, "watchdog expired");
  end

  int star_win[6];

  initial begin
    rst = 1'b1; p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;

    // Reset with both requests active: they are ignored.
    step(1, 1, 1, 24'd5, 24'd6, 1, 1, 24'd7, 24'd8, 0, '0);
    step(1, 1, 0, 24'd5, 24'd6, 1, 0, 24'd7, 24'd8, 0, '0);
    idle(1);

    // Pipeline write 500=35, then read it back.
    step(0, 1, 1, 24'd500, 24'd35, 0, 0, '0, '0, 1, '0);
    step(0, 1, 0, 24'd500, 24'd0, 0, 0, '0, '0, 1, 24'd35);
    idle(1);

    // Preload 700=11 from the pipeline. Loader alone writes 90 to 12, then reads it.
    step(0, 1, 1, 24'd700, 24'd11, 0, 0, '0, '0, 1, '0);
    step(0, 0, 0, '0, '0, 1, 1, 24'd12, 24'd90, 2, '0);
    step(0, 0, 0, '0, '0, 1, 0, 24'd12, 24'd0, 2, 24'd90);
    idle(1);

    // Simultaneous reads: the pipeline wins.
    step(0, 1, 0, 24'd700, '0, 1, 0, 24'd500, '0, 1, 24'd11);
    idle(1);

    // Read, then a same-address write next cycle: the read returns the old data.
    step(0, 1, 0, 24'd500, '0, 0, 0, '0, '0, 1, 24'd35);
    step(0, 0, 0, '0, '0, 1, 1, 24'd500, 24'd77, 2, '0);
    step(0, 1, 0, 24'd500, '0, 0, 0, '0, '0, 1, 24'd77);
    // Back-to-back grants: loader, loader, pipeline, loader.
    step(0, 0, 0, '0, '0, 1, 0, 24'd12, '0, 2, 24'd90);
    step(0, 0, 0, '0, '0, 1, 0, 24'd500, '0, 2, 24'd77);
    step(0, 1, 0, 24'd700, '0, 0, 0, '0, '0, 1, 24'd11);
    step(0, 0, 0, '0, '0, 1, 0, 24'd12, '0, 2, 24'd90);
    idle(2);

    // Both requests held continuously.
`ifdef STARVE_GUARD_EN
    star_win = '{1, 1, 1, 1, 2, 1};
`else
    star_win = '{1, 1, 1, 1, 1, 1};
`endif
    for (int i = 0; i < 6; i++)
      step(0, 1, 0, 24'd700, '0, 1, 0, 24'd12, '0, star_win[i],
           (star_win[i] == 2) ? 24'd90 : 24'd11);

    // Three idle cycles: the port is zeroed and no response arrives.
    idle(3);
    chk("idle_p_rvalid", p_rvalid, 0);
    chk("idle_l_rvalid", l_rvalid, 0);

    // A pipeline read in flight is suppressed by reset in the following cycle.
    step(0, 1, 0, 24'd700, '0, 0, 0, '0, '0, 1, 24'd11);
    step(1, 1, 0, 24'd700, '0, 1, 0, 24'd12, '0, 0, '0);
    idle(3);
    chk("sb_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
